// File: rtl/mem_port_if.sv
// Shared cache-port bundle: fetch and memory-stage request/response
// channels plus the single cache request/completion channel.
interface mem_port_if;
  logic        if_req;
  logic [63:0] if_addr;
  logic [63:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_wr_en;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [63:0] d_rdata;
  logic        d_done;
  logic        flush;
  logic        cache_enable;
  logic        cache_wr_en;
  logic [63:0] cache_addr;
  logic [63:0] cache_wr_value;
  logic [63:0] cache_data;
  logic        cache_operation_complete;
  logic        grant_d;

  modport slave (
    input  if_req, if_addr, d_req, d_wr_en,
    input  d_addr, d_wdata, flush,
    input  cache_data, cache_operation_complete,
    output if_rdata, if_done, d_rdata, d_done,
    output cache_enable, cache_wr_en,
    output cache_addr, cache_wr_value, grant_d
  );

  modport master (
    output if_req, if_addr, d_req, d_wr_en,
    output d_addr, d_wdata, flush,
    output cache_data, cache_operation_complete,
    input  if_rdata, if_done, d_rdata, d_done,
    input  cache_enable, cache_wr_en,
    input  cache_addr, cache_wr_value, grant_d
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for the single cache port: data-first with a
// bounded data streak, one transaction in flight, registered outputs.
module mem_port_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic      clk,
  input  logic      rst,
  mem_port_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  state_t      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic        kill_q, kill_d;
  logic        gnt_q, gnt_d;
  logic        en_q, en_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wv_q, wv_d;
  logic [63:0] if_rd_q, if_rd_d;
  logic [63:0] d_rd_q, d_rd_d;
  logic        if_dn_q, if_dn_d;
  logic        d_dn_q, d_dn_d;
  logic        pick_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      streak_q <= '0;
      kill_q   <= 1'b0;
      gnt_q    <= 1'b0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wv_q     <= '0;
      if_rd_q  <= '0;
      d_rd_q   <= '0;
      if_dn_q  <= 1'b0;
      d_dn_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      kill_q   <= kill_d;
      gnt_q    <= gnt_d;
      en_q     <= en_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wv_q     <= wv_d;
      if_rd_q  <= if_rd_d;
      d_rd_q   <= d_rd_d;
      if_dn_q  <= if_dn_d;
      d_dn_q   <= d_dn_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    kill_d   = kill_q;
    gnt_d    = gnt_q;
    en_d     = en_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wv_d     = wv_q;
    if_rd_d  = if_rd_q;
    d_rd_d   = d_rd_q;
    if_dn_d  = 1'b0;
    d_dn_d   = 1'b0;
    pick_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.d_req || bus.if_req) begin
          // fetch wins a tie only once the streak is exhausted
          pick_d = bus.d_req &&
                   !(bus.if_req && streak_q == STREAK_MAX);
          gnt_d  = pick_d;
          en_d   = 1'b1;
          if (pick_d) begin
            addr_d = bus.d_addr;
            we_d   = bus.d_wr_en;
            wv_d   = bus.d_wdata;
            if (!bus.if_req)
              streak_d = '0;
            else if (streak_q != STREAK_MAX)
              streak_d = streak_q + 4'd1;
          end else begin
            addr_d   = bus.if_addr;
            we_d     = 1'b0;
            wv_d     = '0;
            streak_d = '0;
          end
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.flush && !gnt_q)
          kill_d = 1'b1;
        if (bus.cache_operation_complete) begin
          en_d = 1'b0;
          if (gnt_q) begin
            d_dn_d = 1'b1;
            if (!we_q)
              d_rd_d = bus.cache_data;
          end else if (!(kill_q || bus.flush)) begin
            if_dn_d = 1'b1;
            if_rd_d = bus.cache_data;
          end
          kill_d  = 1'b0;
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.cache_enable   = en_q;
  assign bus.cache_wr_en    = we_q;
  assign bus.cache_addr     = addr_q;
  assign bus.cache_wr_value = wv_q;
  assign bus.grant_d        = gnt_q;
  assign bus.if_rdata       = if_rd_q;
  assign bus.if_done        = if_dn_q;
  assign bus.d_rdata        = d_rd_q;
  assign bus.d_done         = d_dn_q;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single shared cache port. Instruction fetch and the memory stage both issue requests; the arbiter grants one at a time, registers its address/data onto the cache port, holds the port enabled until the cache reports completion, and returns read data with a one-cycle done pulse. Data requests have priority, with a bounded-streak rule so fetch is never starved. A pipeline flush suppresses the response to an outstanding fetch.

## Interface
- MAX_D_STREAK, 4: maximum consecutive data grants while a fetch is pending; range 1..15.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request; held high until if_done
- if_addr  in  64  fetch address; stable while if_req
- if_rdata  out  64  fetch read data; valid when if_done
- if_done  out  1  one-cycle completion pulse for fetch
- d_req  in  1  memory-stage request; held high until d_done
- d_wr_en  in  1  1 = store, 0 = load; stable while d_req
- d_addr  in  64  data address
- d_wdata  in  64  store data
- d_rdata  out  64  load data; valid when d_done
- d_done  out  1  one-cycle completion pulse for data
- flush  in  1  pipeline flush
- cache_enable  out  1  port request active
- cache_wr_en  out  1  write strobe qualifier
- cache_addr  out  64  request address
- cache_wr_value  out  64  write data
- cache_data  in  64  read data from cache
- cache_operation_complete  in  1  completion from cache, one or more cycles
- grant_d  out  1  1 = current/last grant is data (debug)

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: if any req high, select winner, latch addr/wdata/wr_en into cache_* regs, set cache_enable=1, record owner → BUSY. Else stay.
- Selection: d_req only → data; if_req only → fetch; both → data unless streak counter == MAX_D_STREAK, then fetch.
- Streak counter (4 bit): +1 on data grant while if_req high; cleared on any fetch grant or on a data grant with if_req low; saturates at MAX_D_STREAK.
- Fetch requests always read: cache_wr_en=0, cache_wr_value=0.
- BUSY: cache_enable held 1, cache_* stable. On cache_operation_complete: cache_enable=0, capture cache_data into owner's rdata register (loads/fetches only; stores leave d_rdata unchanged), assert owner's done → RESP.
- RESP: done deasserted; req inputs ignored this cycle → IDLE. Requester must drop req by the cycle after done, else it is a new request.
- Flush: flush high in any cycle while a fetch grant is in BUSY sets a kill flag; on completion if_done is not asserted and if_rdata is unchanged. Flush does not affect data grants (stores must retire). Flush in IDLE with both reqs pending does not alter selection. Kill flag cleared on entering RESP.
- cache_operation_complete outside BUSY is ignored.
- rst in any state: state → IDLE; all outputs 0, streak 0, kill 0; an in-flight cache access is abandoned (cache is reset in the same cycle).

## Timing
- Request sampled at edge N in IDLE → cache_enable=1 from cycle N+1.
- Complete sampled at edge M in BUSY → done=1 and rdata valid during cycle M+1 (RESP); IDLE from M+2; next grant earliest port-enable at M+3.
- Minimum turnaround per transaction: 3 cycles with single-cycle cache completion.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Single fetch: if_req=1, if_addr=0x1000, cache completes 2 cycles after enable with 0xDEAD → if_done one cycle, if_rdata=0xDEAD, cache_wr_en=0 throughout.
- Store: d_req, d_wr_en=1, d_addr=0x2008, d_wdata=0x55 → cache_addr=0x2008, cache_wr_value=0x55, cache_wr_en=1; d_done pulse; d_rdata unchanged.
- Contention: both reqs held continuously, each re-raised after done → grant order D,D,D,D,I,D,D,D,D,I (MAX_D_STREAK=4).
- Flush: fetch granted, flush pulsed mid-BUSY, completion with 0x1234 → no if_done, if_rdata keeps old value, FSM returns IDLE.
- Reset mid-BUSY: rst during data grant → next cycle cache_enable=0, d_done=0, all outputs 0; later stray cache_operation_complete produces no done.
- Stale req: requester holds d_req one cycle after d_done → exactly one additional grant issued, not two.
